seq_shift_add_multiplier: RTL
=============================

Name: seq_shift_add_multiplier

Overview:
Parametrised multi-cycle shift-add multiplier and the successor to our single-bit-serial multiplier. It accepts two N-bit operands on a start strobe, selects signed or unsigned mode per operation, and processes one multiplier bit per clock. It returns the full 2N-bit product with a one-cycle done pulse, and it adds busy/abort control. It sits as a coprocessor beside the datapath ALU and is driven by a small controller FSM.

Parameters:
N, 32, operand width in bits; legal range 2..64.
CNT_W, $clog2(N+1), iteration counter width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a new multiply; sampled only in IDLE.
abort  input  1  synchronous cancel of an operation in progress.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
multiplier  input  N  operand A; sampled with start.
multiplicand  input  N  operand B; sampled with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when product is updated.
product  output  2N  result of the last completed operation; held until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, internal accumulator, operand and counter registers = 0.
- States:
  - IDLE: start = 1 on an edge loads the operand registers and clears the accumulator and counter, then moves to RUN. Otherwise the block stays in IDLE.
  - RUN: each edge handles one multiplier bit, LSB first. If the bit is 1, the multiplicand magnitude is added into an (N+1)-bit upper accumulator. The {accumulator, multiplier register} pair then shifts right by 1 and the counter increments.
  - On the edge where the counter reaches N: product is written with the final result, done is set, and the state returns to IDLE.
  - abort = 1 in RUN: the state returns to IDLE on that edge. done is not pulsed and product is unchanged. abort is ignored in IDLE.
- Latency: if start is accepted at edge E0, busy is high for the N cycles following E0. product is valid and done is high in the cycle after edge E0+N. Total start-to-done latency is N+1 cycles.
- Signed mode:
  - The absolute values of both operands are taken at load, as N-bit unsigned magnitudes. The most-negative value maps to 2^(N-1) and needs no extra bit.
  - The result sign is the XOR of the operand MSBs, captured at load.
  - If the sign is 1, the 2N-bit magnitude is negated (two's complement) in the same edge that writes product. A zero magnitude stays 0.
- Unsigned mode: operands are used directly and there is no negation.
- Width rules: the carry out of the N-bit add is kept in accumulator bit N and never lost. product is exact for all operand pairs in both modes.
- Start while busy: ignored, with no effect on the running operation.
- Back-to-back operation: start in the cycle where done is high is accepted, because the state is already IDLE. The new operation's busy rises on the next edge.
- Simultaneous events:
  - start and abort together in IDLE: start wins.
  - abort on the final RUN edge: abort wins, so there is no done and no product update.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values, including product = 0.
- Operand inputs may change freely after the start edge. Only the captured copies are used.

Test Plan:
- Reset and idle. Hold rst_n = 0, then release, with no start → busy = 0, done = 0, product = 0 indefinitely.
- Unsigned edge case. N = 8, signed_mode = 0, multiplier = 255, multiplicand = 255:
  - busy is high for exactly 8 cycles.
  - done pulses once, 9 cycles after start.
  - product = 0xFE01, held afterwards.
- Signed cases at N = 8:
  - −3 × 5 (0xFD, 0x05) → product = 0xFFF1.
  - −128 × −128 (0x80, 0x80) → product = 0x4000.
  - 0 × −7 → product = 0x0000.
- Back-to-back with ignored start:
  - 12 × 10 unsigned, then start again in the done cycle with 7 × 6 → product 120, then 42, with done pulses 9 cycles apart.
  - start pulsed mid-RUN → no effect on either operation.
- Abort:
  - 100 × 3 aborted on RUN cycle 4 → busy falls next cycle, no done, product keeps its previous value.
  - A following 2 × 2 → product = 4.
- Asynchronous reset:
  - rst_n asserted between clock edges during RUN → busy, done and product go to 0 immediately, without waiting for a clock edge.
  - After release, start 9 × 9 → product = 81.

Source files
------------

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/operand request and busy/done/product response bundle for the
// sequential shift-add multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned N = 32
);
  logic           start;
  logic           abort;
  logic           signed_mode;
  logic [N-1:0]   multiplier;
  logic [N-1:0]   multiplicand;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, abort, signed_mode, multiplier, multiplicand,
    input  busy, done, product
  );

  modport slave (
    input  start, abort, signed_mode, multiplier, multiplicand,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier: one multiplier bit per clock, LSB first,
// signed operands handled as magnitudes with the sign applied on the last edge.
module seq_shift_add_multiplier #(
  parameter int unsigned N = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seq_shift_add_multiplier_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * N;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     mplr_q, mplr_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [N-1:0]     a_abs, b_abs;
  logic [N:0]       sum;
  logic [PW-1:0]    mag;
  logic             last;

  // Next-state, datapath step and output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;

    // Most-negative input maps to 2^(N-1), which still fits in N bits
    a_abs = (bus.signed_mode && bus.multiplier[N-1])
          ? ({N{1'b0}} - bus.multiplier) : bus.multiplier;
    b_abs = (bus.signed_mode && bus.multiplicand[N-1])
          ? ({N{1'b0}} - bus.multiplicand) : bus.multiplicand;

    sum  = acc_q + {1'b0, (mplr_q[0] ? mcand_q : {N{1'b0}})};
    mag  = {sum, mplr_q[N-1:1]};
    last = (cnt_q == CNT_W'(N - 1));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mplr_d  = a_abs;
          mcand_d = b_abs;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = bus.signed_mode & (bus.multiplier[N-1] ^ bus.multiplicand[N-1]);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d  = {1'b0, sum[N:1]};
          mplr_d = {sum[0], mplr_q[N-1:1]};
          cnt_d  = CNT_W'(cnt_q + 1'b1);
          if (last) begin
            prod_d  = neg_q ? ({PW{1'b0}} - mag) : mag;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule
